// File: rtl/mem_stage24.sv
// Memory/writeback stage of the 24-bit core: LOAD/STORE handshake with data memory, registered RF write.
// Optional access timeout with sticky err is enabled by defining MEM24_TIMEOUT_EN.
module mem_stage24 #(
   parameter int RF_AW   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [23:0]      in_alu_y,
   input  logic [23:0]      in_store_data,
   input  logic [RF_AW-1:0] in_rd,
   output logic             mem_req,
   output logic             mem_we,
   output logic [23:0]      mem_addr,
   output logic [23:0]      mem_wdata,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [23:0]      mem_rdata,
   output logic             wb_en,
   output logic [RF_AW-1:0] wb_rd,
   output logic [23:0]      wb_data,
   output logic             err
);

   // state   | meaning
   // IDLE    | ready for a new instruction
   // REQ     | mem_req asserted, waiting for mem_gnt
   // WAIT    | load granted, waiting for mem_rvalid
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

   localparam logic [1:0] OP_ALU   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_stage24: TIMEOUT out of range 1..255");
   end

   state_t           state_q, state_d;
   logic             mem_we_q, mem_we_d;
   logic [23:0]      mem_addr_q, mem_addr_d;
   logic [23:0]      mem_wdata_q, mem_wdata_d;
   logic [RF_AW-1:0] rd_q, rd_d;
   logic             wb_en_q, wb_en_d;
   logic [RF_AW-1:0] wb_rd_q, wb_rd_d;
   logic [23:0]      wb_data_q, wb_data_d;
   logic             err_q, err_d;
   logic             timeout_hit;

`ifdef MEM24_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt_q, cnt_d;

   // Counter is zero in IDLE, so it reads 0 in the first REQ cycle.
   always_comb begin
      cnt_d = (state_q == ST_IDLE) ? 8'd0 : cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
   end

   // >= rather than == so a load granted on its last cycle still aborts in WAIT.
   assign timeout_hit = (cnt_q >= TO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rd_d        = rd_q;
      wb_en_d     = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (in_op == OP_ALU) begin
                  wb_en_d   = |in_rd;
                  wb_rd_d   = in_rd;
                  wb_data_d = in_alu_y;
               end else if (in_op == OP_LOAD || in_op == OP_STORE) begin
                  state_d     = ST_REQ;
                  mem_addr_d  = in_alu_y;
                  mem_we_d    = (in_op == OP_STORE);
                  mem_wdata_d = (in_op == OP_STORE) ? in_store_data : 24'd0;
                  rd_d        = in_rd;
               end
            end
         end
         ST_REQ: begin
            if (mem_gnt) begin
               state_d = mem_we_q ? ST_IDLE : ST_WAIT;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               state_d   = ST_IDLE;
               wb_en_d   = |rd_q;
               wb_rd_d   = rd_q;
               wb_data_d = mem_rdata;
            end else if (timeout_hit) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 24'd0;
         mem_wdata_q <= 24'd0;
         rd_q        <= '0;
         wb_en_q     <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= 24'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rd_q        <= rd_d;
         wb_en_q     <= wb_en_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         err_q       <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign mem_req   = (state_q == ST_REQ);
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign wb_en     = wb_en_q;
   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
`ifdef MEM24_TIMEOUT_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage24.sv
// Directed-vector bench for mem_stage24; timeout checks apply when MEM24_TIMEOUT_EN is defined.
module tb_mem_stage24;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [23:0] in_alu_y;
   logic [23:0] in_store_data;
   logic [3:0]  in_rd;
   logic        mem_req;
   logic        mem_we;
   logic [23:0] mem_addr;
   logic [23:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [23:0] mem_rdata;
   logic        wb_en;
   logic [3:0]  wb_rd;
   logic [23:0] wb_data;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_stage24 #(.RF_AW(4), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_alu_y(in_alu_y), .in_store_data(in_store_data), .in_rd(in_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [23:0] y, input logic [23:0] sd,
                        input logic [3:0] rd);
      in_valid      = 1'b1;
      in_op         = op;
      in_alu_y      = y;
      in_store_data = sd;
      in_rd         = rd;
      step();
      in_valid      = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_err", err, 0);
      #2 rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_alu_y = '0; in_store_data = '0;
      in_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #3;
      do_reset();

      // back-to-back ALU writebacks
      chk("alu_ready_before", in_ready, 1);
      in_valid = 1'b1; in_op = 2'b00; in_alu_y = 24'h00ABCD; in_rd = 4'd3;
      step();
      chk("alu1_wb_en", wb_en, 1);
      chk("alu1_wb_data", wb_data, 32'h00ABCD);
      chk("alu1_wb_rd", wb_rd, 3);
      chk("alu1_ready", in_ready, 1);
      in_alu_y = 24'h000777; in_rd = 4'd7;
      step();
      in_valid = 1'b0;
      chk("alu2_wb_en", wb_en, 1);
      chk("alu2_wb_data", wb_data, 32'h000777);
      chk("alu2_wb_rd", wb_rd, 7);
      step();
      chk("alu_pulse_end", wb_en, 0);

      // LOAD: grant after 2 REQ cycles, spurious rvalid in grant cycle, data 3 cycles later
      issue(2'b01, 24'h000010, 24'h0, 4'd5);
      for (int i = 0; i < 2; i++) begin
         chk("ld_req", mem_req, 1);
         chk("ld_we", mem_we, 0);
         chk("ld_addr", mem_addr, 32'h000010);
         chk("ld_ready", in_ready, 0);
         if (i == 1) begin
            mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 24'h0BADBD;
         end
         step();
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("ld_req_drop", mem_req, 0);
      chk("ld_gnt_rvalid_ignored", wb_en, 0);
      for (int i = 0; i < 2; i++) begin
         chk("ld_wait_ready", in_ready, 0);
         step();
      end
      chk("ld_wait_ready", in_ready, 0);
      mem_rvalid = 1'b1; mem_rdata = 24'h123456;
      step();
      mem_rvalid = 1'b0;
      chk("ld_wb_en", wb_en, 1);
      chk("ld_wb_data", wb_data, 32'h123456);
      chk("ld_wb_rd", wb_rd, 5);
      chk("ld_ready_after", in_ready, 1);
      step();
      chk("ld_pulse_end", wb_en, 0);

      // STORE with immediate grant
      issue(2'b10, 24'h000020, 24'hFFFFFF, 4'd9);
      chk("st_req", mem_req, 1);
      chk("st_we", mem_we, 1);
      chk("st_addr", mem_addr, 32'h000020);
      chk("st_wdata", mem_wdata, 32'hFFFFFF);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("st_req_drop", mem_req, 0);
      chk("st_ready", in_ready, 1);
      chk("st_no_wb", wb_en, 0);

      // LOAD to R0: access completes, no write strobe
      issue(2'b01, 24'h000030, 24'h0, 4'd0);
      chk("r0_wdata_zero", mem_wdata, 0);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 24'hABCDEF;
      step();
      mem_rvalid = 1'b0;
      chk("r0_wb_en", wb_en, 0);
      chk("r0_wb_data", wb_data, 32'hABCDEF);
      chk("r0_wb_rd", wb_rd, 0);
      chk("r0_ready", in_ready, 1);

      // op 11: nothing happens
      issue(2'b11, 24'h000055, 24'h0, 4'd4);
      chk("nop_req", mem_req, 0);
      chk("nop_wb_en", wb_en, 0);
      chk("nop_wb_data_hold", wb_data, 32'hABCDEF);
      chk("nop_ready", in_ready, 1);

      // reset during WAIT, then late rvalid
      issue(2'b01, 24'h000040, 24'h0, 4'd6);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("rw_in_wait", in_ready, 0);
      do_reset();
      mem_rvalid = 1'b1; mem_rdata = 24'h111111;
      step();
      mem_rvalid = 1'b0;
      chk("rw_late_rvalid_wb_en", wb_en, 0);
      chk("rw_late_rvalid_wb_data", wb_data, 0);

`ifdef MEM24_TIMEOUT_EN
      // never-granted LOAD aborts after 4 cycles
      issue(2'b01, 24'h000050, 24'h0, 4'd2);
      for (int i = 0; i < 3; i++) begin
         chk("to_req_held", mem_req, 1);
         chk("to_err_low", err, 0);
         step();
      end
      chk("to_req_held", mem_req, 1);
      step();
      chk("to_req_drop", mem_req, 0);
      chk("to_err_set", err, 1);
      chk("to_ready", in_ready, 1);
      chk("to_no_wb", wb_en, 0);
      issue(2'b00, 24'h000042, 24'h0, 4'd1);
      chk("to_alu_wb_en", wb_en, 1);
      chk("to_alu_wb_data", wb_data, 32'h000042);
      chk("to_err_sticky", err, 1);
      step();
      chk("to_err_sticky2", err, 1);
      do_reset();
`else
      // without timeout the stage waits indefinitely
      issue(2'b01, 24'h000050, 24'h0, 4'd2);
      for (int i = 0; i < 8; i++) step();
      chk("nto_req_held", mem_req, 1);
      chk("nto_ready_low", in_ready, 0);
      chk("nto_err_low", err, 0);
      do_reset();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
